// File: rtl/mult_seq_pkg.sv
// Shared types and sizes for the multiplier job sequencer.
// Product width leaves one guard bit above the 2*L_WORD product.
package mult_seq_pkg;
  localparam int L_WORD     = 4;
  localparam int P_WIDTH    = 2 * L_WORD + 1;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    BUSY,
    CAPT
  } state_t;
endpackage

// File: rtl/mult_seq_fifo.sv
// Operand-pair FIFO; pointers carry an extra MSB so that
// full and empty can be told apart without a separate counter.
module mult_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/mult_job_sequencer.sv
// Feeds queued operand pairs to the shift-add multiplier and returns results.
// MULT_SEQ_ZERO_BYPASS_EN: zero-operand pairs skip the multiplier entirely.
module mult_job_sequencer
  import mult_seq_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [L_WORD-1:0]  in_word1,
  input  logic [L_WORD-1:0]  in_word2,
  output logic [L_WORD-1:0]  mul_word1,
  output logic [L_WORD-1:0]  mul_word2,
  output logic               mul_start,
  input  logic               mul_ready,
  input  logic [P_WIDTH-1:0] mul_product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] out_product,
  output logic [7:0]         jobs_done
);
  state_t              state;
  logic                alive;
  logic                full;
  logic                empty;
  logic [2*L_WORD-1:0] head;
  logic                push;
  logic                pop;
  logic                go;
  logic                bypass;

  assign in_ready = alive & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = go | bypass;

`ifdef MULT_SEQ_ZERO_BYPASS_EN
  logic head_zero;
  assign head_zero = (head[2*L_WORD-1:L_WORD] == '0) ||
                     (head[L_WORD-1:0] == '0);
  assign go = (state == IDLE) & ~empty & ~out_valid &
              mul_ready & ~head_zero;
  assign bypass = (state == IDLE) & ~empty & ~out_valid &
                  head_zero;
`else
  assign go = (state == IDLE) & ~empty & ~out_valid & mul_ready;
  assign bypass = 1'b0;
`endif

  mult_seq_fifo #(
    .W     (2 * L_WORD),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({in_word1, in_word2}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      alive       <= 1'b0;
      mul_word1   <= '0;
      mul_word2   <= '0;
      mul_start   <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
      jobs_done   <= '0;
    end else begin
      alive     <= 1'b1;
      mul_start <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        jobs_done <= jobs_done + 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (go) begin
            state     <= ISSUE;
            mul_word1 <= head[2*L_WORD-1:L_WORD];
            mul_word2 <= head[L_WORD-1:0];
            mul_start <= 1'b1;
          end else if (bypass) begin
            out_product <= '0;
            out_valid   <= 1'b1;
          end
        end
        ISSUE: state <= ARM;
        // Ready already high here means the multiplier flushed on Empty
        ARM:   state <= mul_ready ? CAPT : BUSY;
        BUSY:  if (mul_ready) state <= CAPT;
        CAPT: begin
          out_product <= mul_product;
          out_valid   <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
